// File: rtl/rdata_demux_if.sv
// R-channel bundle for the 1-to-N read-data demux: one upstream slave stream,
// NUM_M flattened downstream master streams, plus the drop-error status.
interface rdata_demux_if #(
  parameter int unsigned NUM_M  = 4,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DATA_W = 32
);
  logic [ID_W-1:0]         rid_s;
  logic [DATA_W-1:0]       rdata_s;
  logic [1:0]              rresp_s;
  logic                    rlast_s;
  logic                    rvalid_s;
  logic                    rready_s;

  logic [NUM_M*ID_W-1:0]   rid_m;
  logic [NUM_M*DATA_W-1:0] rdata_m;
  logic [NUM_M*2-1:0]      rresp_m;
  logic [NUM_M-1:0]        rlast_m;
  logic [NUM_M-1:0]        rvalid_m;
  logic [NUM_M-1:0]        rready_m;

  logic                    route_err;
  logic [7:0]              drop_cnt;
  logic                    err_clr;

  // Demux view: consumes the slave stream, produces the master streams.
  modport slave (
    input  rid_s, rdata_s, rresp_s, rlast_s, rvalid_s, rready_m, err_clr,
    output rready_s, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m, route_err, drop_cnt
  );

  // Environment view: drives the slave stream and master readies.
  modport master (
    output rid_s, rdata_s, rresp_s, rlast_s, rvalid_s, rready_m, err_clr,
    input  rready_s, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m, route_err, drop_cnt
  );
endinterface

// File: rtl/rdata_demux_1ton.sv
// AXI R-channel demux: routes one slave R stream to NUM_M master ports by a RID
// bit-field through a 2-entry FIFO; out-of-range destinations are dropped and counted.
module rdata_demux_1ton #(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEL_LSB = 1
) (
  input  logic          aclk,
  input  logic          areset,
  rdata_demux_if.slave  bus
);

  localparam int unsigned SEL_W = $clog2(NUM_M);
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [SEL_W-1:0]  dest;
  } beat_t;

  beat_t             mem_q [DEPTH];
  beat_t             mem_d [DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              rready_q, rready_d;
  logic              route_err_q, route_err_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  beat_t             in_beat;
  beat_t             head;
  logic              dest_ok;
  logic              accept, push, drop, pop;
  logic [NUM_M-1:0]  rvalid_c;

  always_comb begin
    in_beat      = '0;
    in_beat.id   = bus.rid_s;
    in_beat.data = bus.rdata_s;
    in_beat.resp = bus.rresp_s;
    in_beat.last = bus.rlast_s;
    in_beat.dest = bus.rid_s[SEL_LSB +: SEL_W];
  end

  // A power-of-two port count makes every destination code legal.
  if (NUM_M == (1 << SEL_W)) begin : g_pow2
    assign dest_ok = 1'b1;
  end else begin : g_npow2
    assign dest_ok = (in_beat.dest < SEL_W'(NUM_M));
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    rvalid_c = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      rvalid_c[k] = (count_q != 2'd0) && (head.dest == SEL_W'(k));
    end
  end

  assign accept = bus.rvalid_s & rready_q;
  assign push   = accept & dest_ok;
  assign drop   = accept & ~dest_ok;
  assign pop    = |(rvalid_c & bus.rready_m);

  // FIFO bookkeeping, ready generation and drop statistics.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    route_err_d = route_err_q;
    drop_cnt_d  = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_beat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Registered so ready never depends on master-side inputs and stays low in reset.
    rready_d = (count_d != 2'd2);

    if (bus.err_clr) begin
      route_err_d = 1'b0;
      drop_cnt_d  = 8'd0;
    end else if (drop) begin
      route_err_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      rready_q    <= 1'b0;
      route_err_q <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rready_q    <= rready_d;
      route_err_q <= route_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Head beat is broadcast; only the addressed master sees rvalid.
  assign bus.rid_m     = {NUM_M{head.id}};
  assign bus.rdata_m   = {NUM_M{head.data}};
  assign bus.rresp_m   = {NUM_M{head.resp}};
  assign bus.rlast_m   = {NUM_M{head.last}};
  assign bus.rvalid_m  = rvalid_c;
  assign bus.rready_s  = rready_q;
  assign bus.route_err = route_err_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rdata_demux_1ton.sv
// Bench for rdata_demux_1ton: a 4-port instance checked by a beat scoreboard and a
// vector table, and a 3-port instance exercising out-of-range drops and the counter.
module tb_rdata_demux_1ton;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;

  logic aclk;
  logic areset;

  rdata_demux_if #(.NUM_M(4), .ID_W(ID_W), .DATA_W(DATA_W)) d4 ();
  rdata_demux_if #(.NUM_M(3), .ID_W(ID_W), .DATA_W(DATA_W)) d3 ();

  rdata_demux_1ton #(.NUM_M(4), .ID_W(ID_W), .DATA_W(DATA_W), .SEL_LSB(1)) u4 (
    .aclk(aclk), .areset(areset), .bus(d4.slave));
  rdata_demux_1ton #(.NUM_M(3), .ID_W(ID_W), .DATA_W(DATA_W), .SEL_LSB(1)) u3 (
    .aclk(aclk), .areset(areset), .bus(d3.slave));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  dest;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  typedef struct {
    logic [3:0]  rid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  rready_m;
    logic [3:0]  exp_vld;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t push_e;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard: compare the head against the oldest expected beat, then record new accepts.
  always @(negedge aclk) begin
    if (d4.rvalid_m != 4'b0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_vld", 128'(d4.rvalid_m), 128'(0));
      end else begin
        mon_e = sb[0];
        chk("m_vld",  128'(d4.rvalid_m), 128'(4'b0001 << mon_e.dest));
        chk("m_id",   128'(d4.rid_m),    128'({4{mon_e.id}}));
        chk("m_data", 128'(d4.rdata_m),  128'({4{mon_e.data}}));
        chk("m_resp", 128'(d4.rresp_m),  128'({4{mon_e.resp}}));
        chk("m_last", 128'(d4.rlast_m),  128'({4{mon_e.last}}));
        if (d4.rready_m[mon_e.dest]) void'(sb.pop_front());
      end
    end
    if (areset && d4.rvalid_s && d4.rready_s) begin
      push_e.dest = d4.rid_s[2:1];
      push_e.id   = d4.rid_s;
      push_e.data = d4.rdata_s;
      push_e.resp = d4.rresp_s;
      push_e.last = d4.rlast_s;
      sb.push_back(push_e);
    end
  end

  task automatic set4(input logic [3:0] rid, input logic [31:0] data,
                      input logic [1:0] resp, input logic last);
    d4.rid_s    = rid;
    d4.rdata_s  = data;
    d4.rresp_s  = resp;
    d4.rlast_s  = last;
    d4.rvalid_s = 1'b1;
  endtask

  // Hold the driven beat until the edge that accepts it, then drop rvalid.
  task automatic wait_acc4();
    int n = 0;
    while (!d4.rready_s && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 128'(n), 128'(0));
    @(posedge aclk); #1;
    d4.rvalid_s = 1'b0;
  endtask

  task automatic send4(input logic [3:0] rid, input logic [31:0] data,
                       input logic [1:0] resp, input logic last);
    set4(rid, data, resp, last);
    wait_acc4();
  endtask

  task automatic drain4();
    int n = 0;
    while ((sb.size() != 0 || d4.rvalid_m != 4'b0) && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("sb_drained", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    // dest 2 burst of four, then dest 0,3,0 interleave; all masters ready
    tbl[0] = '{4'b0100, 32'hA000_0001, 2'b00, 1'b0, 4'hF, 4'b0100};
    tbl[1] = '{4'b0100, 32'hA000_0002, 2'b01, 1'b0, 4'hF, 4'b0100};
    tbl[2] = '{4'b0100, 32'hA000_0003, 2'b10, 1'b0, 4'hF, 4'b0100};
    tbl[3] = '{4'b0100, 32'hA000_0004, 2'b11, 1'b1, 4'hF, 4'b0100};
    tbl[4] = '{4'b0001, 32'hB000_0000, 2'b00, 1'b1, 4'hF, 4'b0001};
    tbl[5] = '{4'b0111, 32'hB000_0003, 2'b10, 1'b1, 4'hF, 4'b1000};
    tbl[6] = '{4'b0000, 32'hB000_0010, 2'b01, 1'b1, 4'hF, 4'b0001};

    // Reset with valid asserted upstream
    areset = 1'b0;
    set4(4'b0100, 32'hDEAD_BEEF, 2'b00, 1'b0);
    d4.rready_m = 4'hF;
    d4.err_clr  = 1'b0;
    d3.rid_s    = 4'b0110;
    d3.rdata_s  = 32'h3333_0000;
    d3.rresp_s  = 2'b00;
    d3.rlast_s  = 1'b0;
    d3.rvalid_s = 1'b1;
    d3.rready_m = 3'b111;
    d3.err_clr  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_rready4", 128'(d4.rready_s), 128'(0));
    chk("rst_vld4",    128'(d4.rvalid_m), 128'(0));
    chk("rst_data4",   128'(d4.rdata_m),  128'(0));
    chk("rst_rready3", 128'(d3.rready_s), 128'(0));
    chk("rst_cnt3",    128'(d3.drop_cnt), 128'(0));
    chk("rst_err3",    128'(d3.route_err), 128'(0));
    areset      = 1'b1;
    d4.rvalid_s = 1'b0;
    d3.rvalid_s = 1'b0;
    @(posedge aclk); #1;
    chk("rel_rready4", 128'(d4.rready_s), 128'(1));
    chk("rel_rready3", 128'(d3.rready_s), 128'(1));

    // Table: each beat must be the only valid one the cycle after its accept
    for (int i = 0; i < 7; i++) begin
      d4.rready_m = tbl[i].rready_m;
      send4(tbl[i].rid, tbl[i].data, tbl[i].resp, tbl[i].last);
      chk("vec_vld", 128'(d4.rvalid_m), 128'(tbl[i].exp_vld));
    end
    @(posedge aclk); #1;
    chk("vec_idle", 128'(d4.rvalid_m), 128'(0));

    // Backpressure on master 1: two beats fill the FIFO, third waits
    d4.rready_m = 4'b1101;
    send4(4'b0010, 32'hC000_0001, 2'b00, 1'b0);
    send4(4'b0011, 32'hC000_0002, 2'b01, 1'b0);
    set4(4'b0010, 32'hC000_0003, 2'b10, 1'b1);
    chk("bp_full_rready", 128'(d4.rready_s), 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      chk("bp_stall_rready", 128'(d4.rready_s), 128'(0));
      chk("bp_stall_vld",    128'(d4.rvalid_m), 128'(4'b0010));
    end
    d4.rready_m = 4'hF;
    wait_acc4();
    drain4();

    // Out-of-range destination on the 3-port instance
    d3.rid_s    = 4'b0110;
    d3.rvalid_s = 1'b1;
    @(posedge aclk); #1;
    d3.rvalid_s = 1'b0;
    chk("drop_vld",    128'(d3.rvalid_m),  128'(0));
    chk("drop_err",    128'(d3.route_err), 128'(1));
    chk("drop_cnt1",   128'(d3.drop_cnt),  128'(1));
    chk("drop_rready", 128'(d3.rready_s),  128'(1));
    d3.rid_s    = 4'b0101;
    d3.rdata_s  = 32'h3333_0002;
    d3.rvalid_s = 1'b1;
    @(posedge aclk); #1;
    d3.rvalid_s = 1'b0;
    chk("m3_vld",  128'(d3.rvalid_m), 128'(3'b100));
    chk("m3_data", 128'(d3.rdata_m[2*DATA_W +: DATA_W]), 128'(32'h3333_0002));
    @(posedge aclk); #1;
    chk("m3_popped", 128'(d3.rvalid_m), 128'(0));
    chk("m3_cnt_kept", 128'(d3.drop_cnt), 128'(1));

    // Clear wins over a same-cycle drop
    d3.rid_s    = 4'b0110;
    d3.rvalid_s = 1'b1;
    d3.err_clr  = 1'b1;
    @(posedge aclk); #1;
    d3.err_clr  = 1'b0;
    chk("clr_err", 128'(d3.route_err), 128'(0));
    chk("clr_cnt", 128'(d3.drop_cnt),  128'(0));
    // Saturation: rvalid held with an illegal destination drops one beat per cycle
    repeat (254) @(posedge aclk);
    #1;
    chk("sat_254", 128'(d3.drop_cnt), 128'(254));
    @(posedge aclk); #1;
    chk("sat_255", 128'(d3.drop_cnt), 128'(255));
    repeat (45) @(posedge aclk);
    #1;
    d3.rvalid_s = 1'b0;
    chk("sat_300", 128'(d3.drop_cnt),  128'(255));
    chk("sat_err", 128'(d3.route_err), 128'(1));
    d3.err_clr = 1'b1;
    @(posedge aclk); #1;
    d3.err_clr = 1'b0;
    chk("clr2_cnt", 128'(d3.drop_cnt), 128'(0));

    // Asynchronous reset with a full FIFO discards both beats
    d4.rready_m = 4'b1101;
    send4(4'b0010, 32'hE000_0001, 2'b00, 1'b0);
    send4(4'b0011, 32'hE000_0002, 2'b00, 1'b0);
    chk("full_rready", 128'(d4.rready_s), 128'(0));
    #1;
    areset = 1'b0;
    sb.delete();
    #1;
    chk("arst_vld",    128'(d4.rvalid_m), 128'(0));
    chk("arst_rready", 128'(d4.rready_s), 128'(0));
    chk("arst_data",   128'(d4.rdata_m),  128'(0));
    repeat (2) @(posedge aclk);
    #1;
    areset      = 1'b1;
    d4.rready_m = 4'hF;
    @(posedge aclk); #1;
    chk("arst_rel_rready", 128'(d4.rready_s), 128'(1));
    chk("arst_rel_vld",    128'(d4.rvalid_m), 128'(0));
    send4(4'b0001, 32'hF000_0001, 2'b11, 1'b1);
    chk("post_rst_vld", 128'(d4.rvalid_m), 128'(4'b0001));
    drain4();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
